laser_point_feeder: RTL and testbench

- Host-side driver for the two-circle laser-placement engine. The engine receives 40 (X,Y) points per image and returns C1X/C1Y/C2X/C2Y with a DONE pulse.
- This block stores NUM_IMG images of point data, loaded through a simple write port. It streams each image to the engine one point per clock, then waits for DONE, captures the four result coordinates and moves on to the next image.
- It sits between the configuration/host bus and the engine's X/Y/DONE/C* pins.

---
 rtl/laser_point_feeder_if.sv | 63 ++++++
 rtl/laser_point_feeder.sv | 242 ++++++++++++++++++++++++
 tb/tb_laser_point_feeder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/laser_point_feeder_if.sv
// ---------------------------------------------------------------------------
// laser_point_feeder_if
//   Groups the host write port, the run control/status signals and the
//   laser-placement engine pins driven or observed by laser_point_feeder.
//
//   Host write port : wr_en, wr_addr, wr_x, wr_y
//   Run control     : start, busy, img_idx, all_done, timeout_err, proto_err
//   Engine side     : X, Y (points out), DONE, C1X, C1Y, C2X, C2Y (results in)
//   Captured result : res_c1x, res_c1y, res_c2x, res_c2y, res_valid
//
//   The feeder connects through the slave modport. The master modport is the
//   view from the host/engine side, for example a testbench.
// ---------------------------------------------------------------------------
interface laser_point_feeder_if #(
  parameter int ADDR_W = 8,
  parameter int IMG_W  = 2
);
  // Host write port
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_x;
  logic [3:0]        wr_y;

  // Run control
  logic              start;

  // Engine pins
  logic [3:0]        X;
  logic [3:0]        Y;
  logic              DONE;
  logic [3:0]        C1X;
  logic [3:0]        C1Y;
  logic [3:0]        C2X;
  logic [3:0]        C2Y;

  // Captured results and status
  logic [3:0]        res_c1x;
  logic [3:0]        res_c1y;
  logic [3:0]        res_c2x;
  logic [3:0]        res_c2y;
  logic              res_valid;
  logic [IMG_W-1:0]  img_idx;
  logic              busy;
  logic              all_done;
  logic              timeout_err;
  logic              proto_err;

  modport master (
    output wr_en, wr_addr, wr_x, wr_y, start,
    output DONE, C1X, C1Y, C2X, C2Y,
    input  X, Y,
    input  res_c1x, res_c1y, res_c2x, res_c2y, res_valid,
    input  img_idx, busy, all_done, timeout_err, proto_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_x, wr_y, start,
    input  DONE, C1X, C1Y, C2X, C2Y,
    output X, Y,
    output res_c1x, res_c1y, res_c2x, res_c2y, res_valid,
    output img_idx, busy, all_done, timeout_err, proto_err
  );
endinterface

// File: rtl/laser_point_feeder.sv
// ---------------------------------------------------------------------------
// laser_point_feeder
//   Host-side driver for the two-circle laser-placement engine. The block holds
//   NUM_IMG images of NUM_PTS (X,Y) points. After a start pulse it streams each
//   image to the engine at one point per clock. It then waits for DONE,
//   captures the four result coordinates, leaves one idle cycle, and moves on
//   to the next image. A watchdog aborts the run if the engine never answers.
//
//   Ports
//     CLK   : clock, rising edge
//     RST   : asynchronous, active-high reset
//     bus   : laser_point_feeder_if.slave
//             wr_en/wr_addr/wr_x/wr_y  point memory write, accepted in IDLE only
//             start                    begins a run over all images (IDLE only)
//             X/Y                      registered point to the engine
//             DONE, C1X..C2Y           engine result handshake
//             res_*/res_valid          captured result with a one-cycle strobe
//             img_idx, busy            run progress
//             all_done, timeout_err,
//             proto_err                sticky status, cleared by start or RST
// ---------------------------------------------------------------------------
module laser_point_feeder #(
  parameter int NUM_PTS = 40,
  parameter int NUM_IMG = 4,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                 CLK,
  input  logic                 RST,
  laser_point_feeder_if.slave  bus
);

  localparam int DEPTH = NUM_PTS * NUM_IMG;
  localparam int IMG_W = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_GAP,
    S_FINISH
  } state_t;

  // Point memory: each entry is {x, y}.
  logic [7:0]        mem [DEPTH];

  state_t            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;       // index of the point now on X/Y
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [IMG_W-1:0]  img_q, img_d;
  logic [3:0]        x_q, x_d;
  logic [3:0]        y_q, y_d;
  logic [3:0]        c1x_q, c1x_d;
  logic [3:0]        c1y_q, c1y_d;
  logic [3:0]        c2x_q, c2x_d;
  logic [3:0]        c2y_q, c2y_d;
  logic              res_valid_q, res_valid_d;
  logic              busy_q, busy_d;
  logic              all_done_q, all_done_d;
  logic              tout_q, tout_d;
  logic              proto_q, proto_d;

  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  function automatic logic [ADDR_W-1:0] pt_addr(input logic [IMG_W-1:0] img,
                                                input logic [5:0]       pt);
    return ADDR_W'(img) * ADDR_W'(NUM_PTS) + ADDR_W'(pt);
  endfunction

  // NOTE: the point array has no reset. Its contents must survive RST, and
  // leaving it out of the reset tree lets it map onto plain storage.
  always_ff @(posedge CLK) begin
    if (state_q == S_IDLE && bus.wr_en && (32'(bus.wr_addr) < DEPTH))
      mem[bus.wr_addr] <= {bus.wr_x, bus.wr_y};
  end

  // Address of the point that goes onto X/Y at the next edge. On the last
  // point of an image the address is held in range; that read is unused
  // because the FSM drives zeros instead.
  always_comb begin
    rd_addr = '0;
    unique case (state_q)
      S_SEND:  rd_addr = (cnt_q == 6'(NUM_PTS - 1)) ? pt_addr(img_q, '0)
                                                   : pt_addr(img_q, cnt_q + 6'd1);
      S_GAP:   rd_addr = pt_addr(img_q, '0);
      default: rd_addr = '0;
    endcase
  end

  assign rd_data = mem[rd_addr];

  // NOTE: every state register updates with non-blocking assignments. All
  // of them then sample the same pre-edge values, whatever the order of the
  // statements.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wd_q        <= '0;
      img_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      c1x_q       <= '0;
      c1y_q       <= '0;
      c2x_q       <= '0;
      c2y_q       <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      all_done_q  <= 1'b0;
      tout_q      <= 1'b0;
      proto_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      img_q       <= img_d;
      x_q         <= x_d;
      y_q         <= y_d;
      c1x_q       <= c1x_d;
      c1y_q       <= c1y_d;
      c2x_q       <= c2x_d;
      c2y_q       <= c2y_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      all_done_q  <= all_done_d;
      tout_q      <= tout_d;
      proto_q     <= proto_d;
    end
  end

  // NOTE: every signal gets a default before the case statement. An
  // incomplete assignment path then cannot infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wd_d        = wd_q;
    img_d       = img_q;
    x_d         = x_q;
    y_d         = y_q;
    c1x_d       = c1x_q;
    c1y_d       = c1y_q;
    c2x_d       = c2x_q;
    c2y_d       = c2y_q;
    res_valid_d = 1'b0;
    busy_d      = busy_q;
    all_done_d  = all_done_q;
    tout_d      = tout_q;
    proto_d     = proto_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // Point 0 of image 0 is presented in the same edge that accepts start.
          state_d    = S_SEND;
          busy_d     = 1'b1;
          img_d      = '0;
          cnt_d      = '0;
          x_d        = mem[pt_addr('0, '0)][7:4];
          y_d        = mem[pt_addr('0, '0)][3:0];
          all_done_d = 1'b0;
          tout_d     = 1'b0;
          proto_d    = 1'b0;
        end
      end

      S_SEND: begin
        if (cnt_q == 6'(NUM_PTS - 1)) begin
          state_d = S_WAIT;
          x_d     = '0;
          y_d     = '0;
          wd_d    = '0;
        end else begin
          cnt_d = cnt_q + 6'd1;
          x_d   = rd_data[7:4];
          y_d   = rd_data[3:0];
        end
      end

      S_WAIT: begin
        // When DONE and the watchdog limit arrive on the same edge, DONE wins.
        if (bus.DONE) begin
          c1x_d       = bus.C1X;
          c1y_d       = bus.C1Y;
          c2x_d       = bus.C2X;
          c2y_d       = bus.C2Y;
          res_valid_d = 1'b1;
          if (img_q == IMG_W'(NUM_IMG - 1)) begin
            state_d    = S_FINISH;
            all_done_d = 1'b1;
            busy_d     = 1'b0;
          end else begin
            img_d   = img_q + IMG_W'(1);
            state_d = S_GAP;
          end
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          // This edge completes TIMEOUT cycles of waiting.
          tout_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      S_GAP: begin
        // X/Y stayed zero for this one cycle; the next image starts at point 0.
        state_d = S_SEND;
        cnt_d   = '0;
        x_d     = rd_data[7:4];
        y_d     = rd_data[3:0];
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // DONE outside WAIT is flagged and otherwise ignored.
    if (bus.DONE && state_q != S_WAIT)
      proto_d = 1'b1;
  end

  assign bus.X           = x_q;
  assign bus.Y           = y_q;
  assign bus.res_c1x     = c1x_q;
  assign bus.res_c1y     = c1y_q;
  assign bus.res_c2x     = c2x_q;
  assign bus.res_c2y     = c2y_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.img_idx     = img_q;
  assign bus.busy        = busy_q;
  assign bus.all_done    = all_done_q;
  assign bus.timeout_err = tout_q;
  assign bus.proto_err   = proto_q;

endmodule

// File: tb/tb_laser_point_feeder.sv
// ---------------------------------------------------------------------------
// tb_laser_point_feeder
//   Self-checking bench for laser_point_feeder. A reference array holds the
//   point memory contents the host is supposed to have written. The expected
//   stream for image i is entry i*NUM_PTS+k for k = 0..NUM_PTS-1. Engine
//   results come from random values that the bench itself drives.
// ---------------------------------------------------------------------------
module tb_laser_point_feeder;

  localparam int NUM_PTS = 40;
  localparam int NUM_IMG = 4;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 1023;
  localparam int DEPTH   = NUM_PTS * NUM_IMG;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;
  int pts_sent    = 0;

  logic [3:0] m_x [DEPTH];
  logic [3:0] m_y [DEPTH];

  laser_point_feeder_if #(.ADDR_W(ADDR_W), .IMG_W(2)) bus ();

  laser_point_feeder #(
    .NUM_PTS (NUM_PTS),
    .NUM_IMG (NUM_IMG),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Count every cycle with res_valid high, sampled mid-cycle.
  always @(negedge clk) if (bus.res_valid === 1'b1) pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_pt(input int addr, input logic [3:0] x, input logic [3:0] y);
    bus.wr_en   = 1'b1;
    bus.wr_addr = ADDR_W'(addr);
    bus.wr_x    = x;
    bus.wr_y    = y;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic start_run();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_busy",     32'(bus.busy),        32'd1);
    check("start_all_done", 32'(bus.all_done),    32'd0);
    check("start_tout",     32'(bus.timeout_err), 32'd0);
    check("start_proto",    32'(bus.proto_err),   32'd0);
  endtask

  // Expects point 0 of img to be on X/Y now. Checks n_chk points. A full image
  // ends one cycle into WAIT, where X/Y must read zero. glitch >= 0 drives a
  // stray DONE while that point is shown.
  task automatic stream(input int img, input int n_chk, input int glitch);
    for (int k = 0; k < n_chk; k++) begin
      check($sformatf("img%0d_pt%0d_x", img, k), 32'(bus.X), 32'(m_x[img*NUM_PTS + k]));
      check($sformatf("img%0d_pt%0d_y", img, k), 32'(bus.Y), 32'(m_y[img*NUM_PTS + k]));
      if (k == 0 || k == n_chk - 1) begin
        check($sformatf("img%0d_pt%0d_idx", img, k),  32'(bus.img_idx), 32'(img));
        check($sformatf("img%0d_pt%0d_busy", img, k), 32'(bus.busy),    32'd1);
      end
      if (k == glitch) bus.DONE = 1'b1;
      pts_sent++;
      tick();
      bus.DONE = 1'b0;
    end
    if (n_chk == NUM_PTS) begin
      check($sformatf("img%0d_wait_x", img), 32'(bus.X), 32'd0);
      check($sformatf("img%0d_wait_y", img), 32'(bus.Y), 32'd0);
    end
  endtask

  // Waits `delay` cycles in WAIT, returns DONE with random coordinates and
  // checks the capture, the status and the gap cycle.
  task automatic capture(input int img, input int delay);
    logic [15:0] c;
    bit          last;
    last = (img == NUM_IMG - 1);
    repeat (delay) tick();
    c = 16'($urandom);
    bus.C1X  = c[15:12];
    bus.C1Y  = c[11:8];
    bus.C2X  = c[7:4];
    bus.C2Y  = c[3:0];
    bus.DONE = 1'b1;
    tick();
    bus.DONE = 1'b0;
    // Change the engine pins so that the capture must hold its values.
    {bus.C1X, bus.C1Y, bus.C2X, bus.C2Y} = ~c;
    check($sformatf("cap%0d_valid", img), 32'(bus.res_valid), 32'd1);
    check($sformatf("cap%0d_res", img),
          32'({bus.res_c1x, bus.res_c1y, bus.res_c2x, bus.res_c2y}), 32'(c));
    check($sformatf("cap%0d_idx", img),  32'(bus.img_idx), 32'(last ? img : img + 1));
    check($sformatf("cap%0d_busy", img), 32'(bus.busy),     last ? 32'd0 : 32'd1);
    check($sformatf("cap%0d_done", img), 32'(bus.all_done), last ? 32'd1 : 32'd0);
    check($sformatf("cap%0d_gap_x", img), 32'({bus.X, bus.Y}), 32'd0);
    tick();
    check($sformatf("cap%0d_pulse_end", img), 32'(bus.res_valid), 32'd0);
    check($sformatf("cap%0d_hold", img),
          32'({bus.res_c1x, bus.res_c1y, bus.res_c2x, bus.res_c2y}), 32'(c));
  endtask

  // delay < 0 picks a random WAIT delay per image.
  task automatic run_all(input int delay, input int glitch_img);
    start_run();
    check("run_idx0", 32'(bus.img_idx), 32'd0);
    for (int i = 0; i < NUM_IMG; i++) begin
      stream(i, NUM_PTS, (i == glitch_img) ? 20 : -1);
      capture(i, (delay < 0) ? int'($urandom_range(0, 15)) : delay);
    end
    check("run_end_done", 32'(bus.all_done), 32'd1);
    check("run_end_busy", 32'(bus.busy),     32'd0);
  endtask

  initial begin
    int          p0;
    logic [3:0]  rx, ry;

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_x = '0; bus.wr_y = '0;
    bus.start = 1'b0; bus.DONE = 1'b0;
    bus.C1X = '0; bus.C1Y = '0; bus.C2X = '0; bus.C2Y = '0;

    // Reset state
    #2 rst = 1'b1;
    repeat (3) tick();
    check("rst_xy",    32'({bus.X, bus.Y}), 32'd0);
    check("rst_res",   32'({bus.res_c1x, bus.res_c1y, bus.res_c2x, bus.res_c2y}), 32'd0);
    check("rst_flags", 32'({bus.res_valid, bus.busy, bus.all_done,
                            bus.timeout_err, bus.proto_err}), 32'd0);
    check("rst_idx",   32'(bus.img_idx), 32'd0);
    rst = 1'b0;
    tick();

    // Image 0 gets the directed pattern; the other images get random points.
    for (int i = 0; i < DEPTH; i++) begin
      if (i < NUM_PTS) begin
        rx = 4'(i % 16);
        ry = 4'(15 - (i % 16));
      end else begin
        rx = 4'($urandom);
        ry = 4'($urandom);
      end
      m_x[i] = rx;
      m_y[i] = ry;
      write_pt(i, rx, ry);
    end
    // Out-of-range addresses must be dropped.
    write_pt(DEPTH, 4'hF, 4'hF);
    write_pt(255, 4'hA, 4'h5);

    // Run 1: full run, DONE 10 cycles into each WAIT, stray DONE at image 1 point 20
    p0 = pulses;
    pts_sent = 0;
    run_all(10, 1);
    tick();
    check("run1_pulses",   32'(pulses - p0), 32'd4);
    check("run1_points",   32'(pts_sent),    32'(NUM_IMG * NUM_PTS));
    check("run1_proto",    32'(bus.proto_err), 32'd1);
    check("run1_sticky",   32'(bus.all_done),  32'd1);

    // Run 2: DONE on the watchdog edge wins, then a real timeout on image 1
    start_run();
    stream(0, NUM_PTS, -1);
    // Writes and a second start are both ignored while busy.
    bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(5); bus.wr_x = ~m_x[5]; bus.wr_y = ~m_y[5];
    bus.start = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    repeat (TIMEOUT - 2) tick();
    check("wd_edge_busy", 32'(bus.busy),        32'd1);
    check("wd_edge_tout", 32'(bus.timeout_err), 32'd0);
    check("wd_edge_xy",   32'({bus.X, bus.Y}),  32'd0);
    capture(0, 0);
    check("wd_edge_tout_after", 32'(bus.timeout_err), 32'd0);
    stream(1, NUM_PTS, -1);
    p0 = pulses;
    repeat (TIMEOUT - 1) tick();
    check("to_pre_tout", 32'(bus.timeout_err), 32'd0);
    check("to_pre_busy", 32'(bus.busy),        32'd1);
    tick();
    check("to_tout", 32'(bus.timeout_err), 32'd1);
    check("to_busy", 32'(bus.busy),        32'd0);
    tick();
    check("to_no_pulse", 32'(pulses - p0), 32'd0);
    check("to_idx",      32'(bus.img_idx), 32'd1);
    check("to_all_done", 32'(bus.all_done), 32'd0);

    // Run 3: reset during image 2, then a full replay from retained memory
    start_run();
    stream(0, NUM_PTS, -1);
    capture(0, int'($urandom_range(0, 15)));
    stream(1, NUM_PTS, -1);
    capture(1, int'($urandom_range(0, 15)));
    stream(2, 11, -1);
    rst = 1'b1;
    #1;
    check("mid_rst_xy",    32'({bus.X, bus.Y}), 32'd0);
    check("mid_rst_res",   32'({bus.res_c1x, bus.res_c1y, bus.res_c2x, bus.res_c2y}), 32'd0);
    check("mid_rst_flags", 32'({bus.res_valid, bus.busy, bus.all_done,
                                bus.timeout_err, bus.proto_err}), 32'd0);
    check("mid_rst_idx",   32'(bus.img_idx), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_all(-1, -1);
    tick();

    // DONE while idle is a protocol error and nothing else.
    bus.DONE = 1'b1;
    tick();
    bus.DONE = 1'b0;
    check("idle_done_proto", 32'(bus.proto_err), 32'd1);
    check("idle_done_busy",  32'(bus.busy),      32'd0);
    check("idle_done_valid", 32'(bus.res_valid), 32'd0);
    check("idle_done_xy",    32'({bus.X, bus.Y}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
